wavelet_filter_bank: RTL and testbench

- Parametrised successor to the fixed three-filter wavelet front end.
- One delay line feeds NUM_FILTERS dyadic Haar-wavelet filters. Filter f spans BASE_TAPS<<f taps.
- A single shared multiply-free accumulator evaluates the enabled filters one at a time, in order, after each new sample.
- Each filter result leaves on one valid/ready output port, tagged with its filter index. Downstream band processing consumes it.

---
 rtl/wavelet_filter_bank.sv | 197 +++++++++++++++++++
 tb/tb_wavelet_filter_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavelet_filter_bank.sv
// wavelet_filter_bank
//   One delay line feeding NUM_FILTERS dyadic Haar-wavelet filters. Filter f
//   spans BASE_TAPS<<f taps: the newer half is added, the older half is
//   subtracted. A single shared accumulator evaluates the enabled filters
//   one at a time, lowest index first, after every new sample.
//
// Ports
//   clk            system clock
//   i_rst_n        asynchronous active-low reset
//   i_value        signed sample, captured when a data-clock edge is detected
//   i_data_clk     sample strobe, asynchronous to clk (rising edge = new sample)
//   i_enable_mask  per-filter enable, latched once per sample in LOAD
//   i_ready        downstream ready
//   o_sum          signed filter result
//   o_filter_id    index of the filter whose result is on o_sum
//   o_valid        result valid
//   o_busy         high whenever the FSM is not in IDLE
//   o_overrun      sticky: a sample arrived while the pending buffer was full
//
// Handshake: a result transfers on every rising clk edge where o_valid and
// i_ready are both high. While o_valid is high and i_ready is low, o_sum and
// o_filter_id hold their values; o_valid never drops without a transfer
// (except on reset).
module wavelet_filter_bank #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_FILTERS   = 4,
    parameter int BASE_TAPS     = 2,
    parameter int MAX_TAPS      = 16,
    parameter int ACC_BITS      = 32,
    localparam int FID_W        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [BITS_PER_ELEM-1:0] i_value,
    input  logic                     i_data_clk,
    input  logic [NUM_FILTERS-1:0]   i_enable_mask,
    input  logic                     i_ready,
    output logic [ACC_BITS-1:0]      o_sum,
    output logic [FID_W-1:0]         o_filter_id,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_overrun
);

    localparam int IDX_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam int LEN_W = $clog2(MAX_TAPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                     state;
    logic                       sync1, sync2, sync_prev;
    logic                       edge_det;
    logic                       pending_full;
    logic [BITS_PER_ELEM-1:0]   pending_val;
    logic [BITS_PER_ELEM-1:0]   taps [MAX_TAPS];
    logic [NUM_FILTERS-1:0]     mask_q;
    logic [FID_W-1:0]           cur_f;
    logic [IDX_W-1:0]           tap_idx;
    logic [ACC_BITS-1:0]        acc;

    logic [LEN_W-1:0]           cur_len;
    logic [LEN_W-1:0]           tap_k;
    logic                       is_upper;
    logic                       is_last;
    logic [BITS_PER_ELEM-1:0]   cur_tap;
    logic [ACC_BITS-1:0]        tap_ext;
    logic [ACC_BITS-1:0]        next_acc;
    logic                       first_found, next_found;
    logic [FID_W-1:0]           first_f, next_f;

    assign edge_det = sync2 & ~sync_prev;
    assign o_busy   = (state != IDLE);

    // Current filter geometry: taps below half the length are added.
    assign cur_len  = LEN_W'(BASE_TAPS) << cur_f;
    assign tap_k    = LEN_W'(tap_idx);
    assign is_upper = (tap_k >= (cur_len >> 1));
    assign is_last  = (tap_k == (cur_len - LEN_W'(1)));
    assign cur_tap  = taps[tap_idx];
    assign tap_ext  = {{(ACC_BITS-BITS_PER_ELEM){cur_tap[BITS_PER_ELEM-1]}}, cur_tap};
    assign next_acc = is_upper ? (acc - tap_ext) : (acc + tap_ext);

    // Lowest enabled filter in the incoming mask, and the next enabled
    // filter above the current one in the latched mask.
    always_comb begin
        first_found = 1'b0;
        first_f     = '0;
        next_found  = 1'b0;
        next_f      = '0;
        for (int f = NUM_FILTERS - 1; f >= 0; f--) begin
            if (i_enable_mask[f]) begin
                first_found = 1'b1;
                first_f     = FID_W'(f);
            end
            if (mask_q[f] && (f > int'(cur_f))) begin
                next_found = 1'b1;
                next_f     = FID_W'(f);
            end
        end
    end

    // Strobe synchroniser, pending buffer and overrun flag. LOAD empties the
    // buffer, so an edge landing in LOAD refills it without an overrun.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync_prev    <= 1'b0;
            pending_full <= 1'b0;
            pending_val  <= '0;
            o_overrun    <= 1'b0;
        end else begin
            sync1     <= i_data_clk;
            sync2     <= sync1;
            sync_prev <= sync2;
            if (edge_det && (!pending_full || state == LOAD)) begin
                pending_full <= 1'b1;
                pending_val  <= i_value;
            end else begin
                if (edge_det) begin
                    o_overrun <= 1'b1;
                end
                if (state == LOAD) begin
                    pending_full <= 1'b0;
                end
            end
        end
    end

    // Main FSM: delay line, shared accumulator and registered result port.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            for (int k = 0; k < MAX_TAPS; k++) begin
                taps[k] <= '0;
            end
            mask_q      <= '0;
            cur_f       <= '0;
            tap_idx     <= '0;
            acc         <= '0;
            o_sum       <= '0;
            o_filter_id <= '0;
            o_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A fresh edge is captured into the buffer this cycle,
                    // so LOAD can start straight away.
                    if (pending_full || edge_det) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int k = MAX_TAPS - 1; k > 0; k--) begin
                        taps[k] <= taps[k-1];
                    end
                    taps[0] <= pending_val;
                    mask_q  <= i_enable_mask;
                    cur_f   <= first_f;
                    tap_idx <= '0;
                    acc     <= '0;
                    state   <= first_found ? CALC : IDLE;
                end
                CALC: begin
                    acc     <= next_acc;
                    tap_idx <= tap_idx + IDX_W'(1);
                    if (is_last) begin
                        o_sum       <= next_acc;
                        o_filter_id <= cur_f;
                        o_valid     <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                        if (next_found) begin
                            cur_f   <= next_f;
                            tap_idx <= '0;
                            acc     <= '0;
                            state   <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wavelet_filter_bank.sv
// Testbench for wavelet_filter_bank (BASE_TAPS=2, NUM_FILTERS=3, MAX_TAPS=8).
// A reference model keeps the delay line as a plain int array and computes
// each enabled filter's Haar sum directly; results seen on the output port
// are compared in order against the expected queue.
module tb_wavelet_filter_bank;

    localparam int B  = 8;
    localparam int NF = 3;
    localparam int BT = 2;
    localparam int MT = 8;
    localparam int AW = 32;
    localparam int FW = 2;
    localparam int W  = FW + AW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          i_rst_n;
    logic [B-1:0]  i_value;
    logic          i_data_clk;
    logic [NF-1:0] i_enable_mask;
    logic          i_ready;
    logic [AW-1:0] o_sum;
    logic [FW-1:0] o_filter_id;
    logic          o_valid;
    logic          o_busy;
    logic          o_overrun;

    always #5 clk = ~clk;

    wavelet_filter_bank #(
        .BITS_PER_ELEM (B),
        .NUM_FILTERS   (NF),
        .BASE_TAPS     (BT),
        .MAX_TAPS      (MT),
        .ACC_BITS      (AW)
    ) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_value       (i_value),
        .i_data_clk    (i_data_clk),
        .i_enable_mask (i_enable_mask),
        .i_ready       (i_ready),
        .o_sum         (o_sum),
        .o_filter_id   (o_filter_id),
        .o_valid       (o_valid),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           model_line[MT];
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           rand_ready = 1'b0;

    // Transfers are recorded on the falling edge; the handshake completes on
    // the following rising edge.
    always @(negedge clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            got_q.push_back({o_filter_id, o_sum});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_sample(input int v, input int mask);
        for (int k = MT - 1; k > 0; k--) begin
            model_line[k] = model_line[k-1];
        end
        model_line[0] = v;
        for (int f = 0; f < NF; f++) begin
            if (mask[f]) begin
                int len;
                int s;
                len = BT << f;
                s   = 0;
                for (int k = 0; k < len; k++) begin
                    if (k < len / 2) s = s + model_line[k];
                    else             s = s - model_line[k];
                end
                exp_q.push_back({FW'(f), AW'(s)});
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < MT; k++) model_line[k] = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) i_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic strobe(input int v, input int mask, input int hi);
        i_value       = B'(v);
        i_enable_mask = NF'(mask);
        i_data_clk    = 1'b1;
        ticks(hi);
        i_data_clk    = 1'b0;
    endtask

    // Wait for three consecutive quiet cycles so a sample still sitting in
    // the pending buffer gets a chance to start.
    task automatic wait_idle(input string tag);
        int cnt;
        int quiet;
        cnt   = 0;
        quiet = 0;
        while (quiet < 3 && cnt < 400) begin
            tick();
            cnt++;
            if (!o_busy && !o_valid) quiet++;
            else                     quiet = 0;
        end
        check({tag, "_idle_timeout"}, AW'(cnt < 400), AW'(1));
    endtask

    task automatic send(input int v, input int mask, input string tag);
        strobe(v, mask, 4);
        ticks(2);
        model_sample(v, mask);
        wait_idle(tag);
    endtask

    task automatic drain(input string tag);
        logic [W-1:0] g;
        logic [W-1:0] e;
        check({tag, "_count"}, AW'(got_q.size()), AW'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_id"}, AW'(g[W-1:AW]), AW'(e[W-1:AW]));
            check({tag, "_sum"}, g[AW-1:0], e[AW-1:0]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        logic [AW-1:0] hold_sum;
        logic [FW-1:0] hold_id;

        i_rst_n       = 1'b0;
        i_value       = '0;
        i_data_clk    = 1'b0;
        i_enable_mask = '0;
        i_ready       = 1'b1;
        model_reset();
        ticks(3);

        check("rst_sum",     o_sum,             AW'(0));
        check("rst_id",      AW'(o_filter_id),  AW'(0));
        check("rst_valid",   AW'(o_valid),      AW'(0));
        check("rst_busy",    AW'(o_busy),       AW'(0));
        check("rst_overrun", AW'(o_overrun),    AW'(0));
        i_rst_n = 1'b1;
        ticks(2);

        // Impulse of 10 followed by zeros.
        send(10, 7, "imp0");
        drain("impulse_first");
        for (int i = 0; i < 7; i++) begin
            send(0, 7, "imp");
            drain("impulse_tail");
        end

        // Positive step then negative full-scale step.
        for (int i = 0; i < 9; i++) begin
            send(10, 7, "step");
            drain("step_pos");
        end
        for (int i = 0; i < 9; i++) begin
            send(-128, 7, "nstep");
            drain("step_neg");
        end

        // Backpressure: hold i_ready low while a result waits.
        i_ready = 1'b0;
        strobe(50, 7, 4);
        model_sample(50, 7);
        cnt = 0;
        while (!o_valid && cnt < 100) begin
            tick();
            cnt++;
        end
        check("bp_valid_seen", AW'(o_valid), AW'(1));
        check("bp_first_sum", o_sum, exp_q[0][AW-1:0]);
        hold_sum = o_sum;
        hold_id  = o_filter_id;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_valid", AW'(o_valid), AW'(1));
            check("bp_hold_sum",   o_sum, hold_sum);
            check("bp_hold_id",    AW'(o_filter_id), AW'(hold_id));
        end
        i_ready = 1'b1;
        wait_idle("bp");
        drain("backpressure");

        // Mask handling.
        send(33, 2, "mask010");
        drain("mask_010");
        send(7, 0, "mask000");
        drain("mask_000");
        send(3, 1, "mask001");
        drain("mask_001_after_zero");

        // Overrun: three strobes 4 cycles apart during the 8-tap filter.
        check("overrun_before", AW'(o_overrun), AW'(0));
        strobe(20, 4, 2);
        ticks(2);
        strobe(-5, 4, 2);
        ticks(2);
        strobe(99, 4, 2);
        ticks(2);
        model_sample(20, 4);
        model_sample(-5, 4);
        wait_idle("ovr");
        drain("overrun_seq");
        check("overrun_set", AW'(o_overrun), AW'(1));
        send(1, 7, "ovr_after");
        drain("overrun_after");
        check("overrun_sticky", AW'(o_overrun), AW'(1));

        // Randomised samples, masks and ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 7)), "rnd");
            drain("random");
        end
        rand_ready = 1'b0;
        i_ready    = 1'b1;
        ticks(2);

        // Reset in the middle of a calculation.
        strobe(10, 7, 4);
        check("midrst_busy_before", AW'(o_busy), AW'(1));
        i_rst_n = 1'b0;
        #1;
        check("midrst_sum",     o_sum,            AW'(0));
        check("midrst_id",      AW'(o_filter_id), AW'(0));
        check("midrst_valid",   AW'(o_valid),     AW'(0));
        check("midrst_busy",    AW'(o_busy),      AW'(0));
        check("midrst_overrun", AW'(o_overrun),   AW'(0));
        i_data_clk = 1'b0;
        ticks(2);
        got_q.delete();
        exp_q.delete();
        model_reset();
        i_rst_n = 1'b1;
        ticks(2);
        send(10, 7, "post_rst");
        drain("post_reset_impulse");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
